// File: rtl/mem_trap_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_trap_ctrl
// Description : Trap entry/return sequencer for the MEM-stage CSR unit.
//               Arbitrates a pending interrupt against a synchronous system
//               instruction (ecall/ebreak/mret) sitting in MEM. It qualifies
//               CSR commits, flushes the younger stages and issues a one-cycle
//               fetch redirect to the target supplied by the CSR unit. It also
//               counts the interrupts and exceptions taken.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W : instruction address width
//   CNT_W  : width of the interrupt / exception counters (wrap modulo 2^CNT_W)
// Ports
//   clk                      in   clock, rising edge
//   rst                      in   asynchronous reset, active low
//   trap_ctrl_csr_trap_i     in   interrupt pending and enabled
//   trap_ctrl_inst_valid_i   in   valid instruction in MEM
//   trap_ctrl_inst_addr_i    in   PC of the MEM instruction (consumed by CSR)
//   trap_ctrl_inst_ecall_i   in   MEM instruction is ecall
//   trap_ctrl_inst_ebreak_i  in   MEM instruction is ebreak
//   trap_ctrl_inst_mret_i    in   MEM instruction is mret
//   trap_ctrl_lsu_busy_i     in   MEM load/store not yet complete
//   trap_ctrl_csr_nxt_pc_i   in   CSR target (mtvec for trap/intp, else mepc)
//   trap_ctrl_csr_valid_o    out  commit qualifier to the CSR unit
//   trap_ctrl_intp_en_o      out  interrupt-take qualifier to the CSR unit
//   trap_ctrl_stall_o        out  hold IF/ID/EX/MEM pipeline registers
//   trap_ctrl_flush_o        out  kill IF/ID/EX and MEM writeback
//   trap_ctrl_redirect_o     out  fetch redirect strobe
//   trap_ctrl_redirect_pc_o  out  redirect target, registered
//   trap_ctrl_intp_cnt_o     out  interrupts taken
//   trap_ctrl_exc_cnt_o      out  ecall/ebreak/mret taken
// ============================================================================
module mem_trap_ctrl #(
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trap_ctrl_csr_trap_i,
   input  logic              trap_ctrl_inst_valid_i,
   input  logic [ADDR_W-1:0] trap_ctrl_inst_addr_i,
   input  logic              trap_ctrl_inst_ecall_i,
   input  logic              trap_ctrl_inst_ebreak_i,
   input  logic              trap_ctrl_inst_mret_i,
   input  logic              trap_ctrl_lsu_busy_i,
   input  logic [ADDR_W-1:0] trap_ctrl_csr_nxt_pc_i,
   output logic              trap_ctrl_csr_valid_o,
   output logic              trap_ctrl_intp_en_o,
   output logic              trap_ctrl_stall_o,
   output logic              trap_ctrl_flush_o,
   output logic              trap_ctrl_redirect_o,
   output logic [ADDR_W-1:0] trap_ctrl_redirect_pc_o,
   output logic [CNT_W-1:0]  trap_ctrl_intp_cnt_o,
   output logic [CNT_W-1:0]  trap_ctrl_exc_cnt_o
);

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TAKE     = 2'd1,
      ST_EXC      = 2'd2,
      ST_REDIRECT = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_redirect_pc;
   logic [CNT_W-1:0]    r_intp_cnt;
   logic [CNT_W-1:0]    r_exc_cnt;

   logic                w_sys;
   logic                w_ready;
   logic                w_csr_valid;
   logic                w_intp_en;
   logic                w_stall;
   logic                w_flush;
   logic                w_redirect;

   // The MEM PC is routed straight to the CSR unit for mepc; this block only
   // carries it on its boundary so the interface stays uniform.
   logic                w_unused_addr;
   assign w_unused_addr = ^trap_ctrl_inst_addr_i;

   assign w_sys   = trap_ctrl_inst_ecall_i | trap_ctrl_inst_ebreak_i |
                    trap_ctrl_inst_mret_i;
   // A load/store still in flight defers any trap until it completes.
   assign w_ready = trap_ctrl_inst_valid_i & ~trap_ctrl_lsu_busy_i;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output decode
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_csr_valid = 1'b0;
      w_intp_en   = 1'b0;
      w_stall     = 1'b0;
      w_flush     = 1'b0;
      w_redirect  = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            // Ordinary commit only when no trap is about to be taken.
            w_csr_valid = w_ready & ~w_sys & ~trap_ctrl_csr_trap_i;
            // Interrupt has priority over a system instruction in the same cycle.
            if (w_ready && trap_ctrl_csr_trap_i) begin
               w_stall     = 1'b1;
               w_state_nxt = ST_TAKE;
            end else if (w_ready && w_sys) begin
               w_stall     = 1'b1;
               w_state_nxt = ST_EXC;
            end
         end
         ST_TAKE: begin
            // The MEM instruction is not retired; mepc points back at it.
            w_csr_valid = 1'b1;
            w_intp_en   = 1'b1;
            w_flush     = 1'b1;
            w_state_nxt = ST_REDIRECT;
         end
         ST_EXC: begin
            w_csr_valid = 1'b1;
            w_flush     = 1'b1;
            w_state_nxt = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            w_flush     = 1'b1;
            w_redirect  = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Redirect target capture and trap counters
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_redirect_pc <= '0;
         r_intp_cnt    <= '0;
         r_exc_cnt     <= '0;
      end else begin
         // The CSR unit presents mtvec/mepc during the entry cycle; hold it
         // until the next trap so the redirect cycle sees a stable value.
         if ((r_state == ST_TAKE) || (r_state == ST_EXC)) begin
            r_redirect_pc <= trap_ctrl_csr_nxt_pc_i;
         end
         if (r_state == ST_TAKE) begin
            r_intp_cnt <= r_intp_cnt + c_CNT_ONE;
         end
         if (r_state == ST_EXC) begin
            r_exc_cnt <= r_exc_cnt + c_CNT_ONE;
         end
      end
   end

   // Combinational strobes are masked by reset so every output reads zero
   // while reset is asserted, independent of the pipeline inputs.
   assign trap_ctrl_csr_valid_o   = rst & w_csr_valid;
   assign trap_ctrl_intp_en_o     = rst & w_intp_en;
   assign trap_ctrl_stall_o       = rst & w_stall;
   assign trap_ctrl_flush_o       = rst & w_flush;
   assign trap_ctrl_redirect_o    = rst & w_redirect;
   assign trap_ctrl_redirect_pc_o = r_redirect_pc;
   assign trap_ctrl_intp_cnt_o    = r_intp_cnt;
   assign trap_ctrl_exc_cnt_o     = r_exc_cnt;

endmodule
`default_nettype wire
